// File: rtl/counter_pkg.sv
// Shared types and default sizes for the modulo/step counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam int WIDTH_DEF  = 4;
    localparam int STEP_W_DEF = 2;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation for one enabled step, including
// wrap/saturate/one-shot terminal handling and out-of-range recovery.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              up_down,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              wrap_hit,
    output logic              term_hit
);

    // One extra bit above the wider operand so sums never truncate.
    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [CW-1:0] cnt_s;
    logic [CW-1:0] stp_s;
    logic [CW-1:0] lim_s;
    logic [CW-1:0] lim_p1_s;
    logic [CW-1:0] sum_s;
    logic [CW-1:0] res_s;
    logic          is_sat_s;
    logic          is_one_s;

    assign cnt_s    = CW'(count);
    assign stp_s    = CW'(step);
    assign lim_s    = CW'(limit);
    assign lim_p1_s = lim_s + CW'(1'b1);
    assign sum_s    = cnt_s + stp_s;
    assign is_sat_s = (mode == MODE_SAT);
    assign is_one_s = (mode == MODE_ONESHOT);

    // Next count selection by direction and terminal mode.
    always_comb begin
        res_s    = cnt_s;
        wrap_hit = 1'b0;
        term_hit = 1'b0;
        if (cnt_s > lim_s) begin
            // limit was lowered under the current count
            if (is_sat_s) begin
                res_s = lim_s;
            end else begin
                res_s    = {CW{1'b0}};
                term_hit = is_one_s;
                wrap_hit = ~is_one_s;
            end
        end else if (up_down) begin
            if (sum_s <= lim_s) begin
                res_s    = sum_s;
                term_hit = is_one_s && (sum_s == lim_s);
            end else if (is_sat_s) begin
                res_s = lim_s;
            end else if (is_one_s) begin
                res_s    = lim_s;
                term_hit = 1'b1;
            end else begin
                res_s    = sum_s - lim_p1_s;
                wrap_hit = 1'b1;
            end
        end else begin
            if (stp_s <= cnt_s) begin
                res_s    = cnt_s - stp_s;
                term_hit = is_one_s && (cnt_s == stp_s);
            end else if (is_sat_s) begin
                res_s = {CW{1'b0}};
            end else if (is_one_s) begin
                res_s    = {CW{1'b0}};
                term_hit = 1'b1;
            end else begin
                res_s    = cnt_s + lim_p1_s - stp_s;
                wrap_hit = 1'b1;
            end
        end
    end

    assign next_count = WIDTH'(res_s);

endmodule

// File: rtl/counter_mod_step.sv
// Modulo/step up-down counter with wrap, saturate and one-shot terminal modes.
// Holds the count/flag registers, the RUN/DONE FSM and load/enable priority.
module counter_mod_step
    import counter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              ce,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              wrap,
    output logic              done,
    output logic              step_err
);

    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    state_e           state_r;
    state_e           next_state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;
    logic             wrap_r;
    logic             next_wrap_s;
    logic             done_r;
    logic [WIDTH-1:0] calc_count_s;
    logic             calc_wrap_s;
    logic             calc_term_s;
    logic             step_ok_s;
    logic             count_en_s;

    counter_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count      (count_r),
        .step       (step),
        .limit      (limit),
        .up_down    (up_down),
        .mode       (mode),
        .next_count (calc_count_s),
        .wrap_hit   (calc_wrap_s),
        .term_hit   (calc_term_s)
    );

    assign step_ok_s  = (CW'(step) <= CW'(limit));
    assign count_en_s = ce && (step != {STEP_W{1'b0}}) && step_ok_s && (state_r == ST_RUN);

    // Next-state and next-count selection: load > DONE hold > count > hold.
    always_comb begin
        next_state_s = state_r;
        next_count_s = count_r;
        next_wrap_s  = 1'b0;
        if (!load_n) begin
            next_count_s = (data_load > limit) ? limit : data_load;
            next_state_s = ST_RUN;
        end else if (state_r == ST_DONE) begin
            if (mode != MODE_ONESHOT) begin
                next_state_s = ST_RUN;
            end else begin
                next_state_s = ST_DONE;
            end
        end else if (count_en_s) begin
            next_count_s = calc_count_s;
            next_wrap_s  = calc_wrap_s;
            if (calc_term_s) begin
                next_state_s = ST_DONE;
            end else begin
                next_state_s = ST_RUN;
            end
        end else begin
            next_state_s = state_r;
        end
    end

    // State, count and registered flag update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= next_count_s;
            wrap_r  <= next_wrap_s;
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    assign count_out = count_r;
    assign wrap      = wrap_r;
    assign done      = done_r;
    assign max_count = (count_r == limit);
    assign zero      = (count_r == {WIDTH{1'b0}});
    assign step_err  = ce && load_n && !step_ok_s && (state_r == ST_RUN);

endmodule

// File: tb/tb_counter_mod_step.sv
// Table-driven bench for counter_mod_step with a scoreboard queue of expected results.
module tb_counter_mod_step;
    import counter_pkg::*;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_n;
    logic [WIDTH-1:0]  data_load;
    logic              ce;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  count_out;
    logic              max_count;
    logic              zero;
    logic              wrap;
    logic              done;
    logic              step_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              rst;
        logic              load_n;
        logic [WIDTH-1:0]  data_load;
        logic              ce;
        logic              up_down;
        logic [STEP_W-1:0] step;
        logic [WIDTH-1:0]  limit;
        logic [1:0]        mode;
        logic [WIDTH-1:0]  exp_count;
        logic              exp_wrap;
        logic              exp_done;
        logic              exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    counter_mod_step #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_n    (load_n),
        .data_load (data_load),
        .ce        (ce),
        .up_down   (up_down),
        .step      (step),
        .limit     (limit),
        .mode      (mode),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .wrap      (wrap),
        .done      (done),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int ld_n, input int dl, input int c,
                                input int ud, input int st, input int lim, input int md,
                                input int ec, input int ew, input int ed, input int ee);
        vec_t v;
        v.rst = r[0]; v.load_n = ld_n[0]; v.data_load = dl[WIDTH-1:0]; v.ce = c[0];
        v.up_down = ud[0]; v.step = st[STEP_W-1:0]; v.limit = lim[WIDTH-1:0]; v.mode = md[1:0];
        v.exp_count = ec[WIDTH-1:0]; v.exp_wrap = ew[0]; v.exp_done = ed[0]; v.exp_err = ee[0];
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, expv);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst = v.rst; load_n = v.load_n; data_load = v.data_load; ce = v.ce;
        up_down = v.up_down; step = v.step; limit = v.limit; mode = v.mode;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("count", idx, int'(count_out), int'(e.exp_count));
        chk("max_count", idx, int'(max_count), int'(e.exp_count == e.limit));
        chk("zero", idx, int'(zero), int'(e.exp_count == {WIDTH{1'b0}}));
        chk("wrap", idx, int'(wrap), int'(e.exp_wrap));
        chk("done", idx, int'(done), int'(e.exp_done));
        chk("step_err", idx, int'(step_err), int'(e.exp_err));
    endtask

    initial begin
        int W, S, O;
        W = 0; S = 1; O = 2;
        rst = 1'b1; load_n = 1'b1; data_load = 4'd0; ce = 1'b0;
        up_down = 1'b1; step = 2'd1; limit = 4'd9; mode = 2'd0;

        //           rst ld dl ce ud st lim md   cnt w d e
        vecs.push_back(mk(1, 0,  5, 1, 1, 1,  9, W,   0, 0, 0, 0)); // reset beats load/ce
        vecs.push_back(mk(0, 0,  8, 0, 1, 1,  9, W,   8, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 1,  9, W,   9, 0, 0, 0)); // reach limit, no wrap
        vecs.push_back(mk(0, 1,  0, 1, 1, 1,  9, W,   0, 1, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 1,  9, W,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  1, 0, 0, 3,  9, W,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 3,  9, W,   8, 1, 0, 0)); // wrap down
        vecs.push_back(mk(0, 1,  0, 1, 0, 3,  9, W,   5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 11, 0, 1, 3, 12, S,  11, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 3, 12, S,  12, 0, 0, 0)); // saturate
        vecs.push_back(mk(0, 1,  0, 1, 1, 3, 12, S,  12, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 3, 12, S,  12, 0, 0, 0));
        vecs.push_back(mk(0, 0,  2, 0, 0, 1, 12, O,   2, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 1, 12, O,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 1, 12, O,   0, 0, 1, 0)); // one-shot hits 0
        vecs.push_back(mk(0, 1,  0, 1, 0, 1, 12, O,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 1, 12, O,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 1, 12, O,   0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  5, 1, 0, 1, 12, O,   5, 0, 0, 0)); // load leaves DONE
        vecs.push_back(mk(0, 1,  0, 1, 0, 1, 12, O,   4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10, 0, 1, 2, 12, O,  10, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 2, 12, O,  12, 0, 1, 0)); // one-shot hits limit
        vecs.push_back(mk(0, 1,  0, 1, 1, 1, 12, W,  12, 0, 0, 0)); // mode change leaves DONE
        vecs.push_back(mk(0, 1,  0, 1, 1, 1, 12, W,   0, 1, 0, 0));
        vecs.push_back(mk(1, 0,  5, 1, 1, 1,  9, W,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 15, 0, 1, 1,  9, W,   9, 0, 0, 0)); // load clamps to limit
        vecs.push_back(mk(0, 0,  2, 0, 1, 3,  3, W,   2, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 3,  3, W,   1, 1, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 3,  2, W,   1, 0, 0, 1)); // step > limit holds
        vecs.push_back(mk(0, 0,  9, 0, 1, 1,  9, W,   9, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 1, 1,  5, W,   0, 1, 0, 0)); // limit lowered, wrap
        vecs.push_back(mk(0, 0,  9, 0, 1, 1,  9, S,   9, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 1,  5, S,   5, 0, 0, 0)); // limit lowered, sat
        vecs.push_back(mk(0, 1,  0, 1, 1, 0,  9, S,   5, 0, 0, 0)); // step 0 holds
        vecs.push_back(mk(0, 1,  0, 1, 1, 1,  0, W,   5, 0, 0, 1)); // limit 0 step_err
        vecs.push_back(mk(0, 0,  7, 0, 1, 1,  0, W,   0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // step_err is combinational: visible before any clock edge
        @(negedge clk);
        load_n = 1'b1; ce = 1'b1; step = 2'd3; limit = 4'd2; mode = 2'd0; up_down = 1'b1;
        #1 chk("step_err_comb_on", 100, int'(step_err), 1);
        ce = 1'b0;
        #1 chk("step_err_comb_ce0", 101, int'(step_err), 0);
        ce = 1'b1; step = 2'd2;
        #1 chk("step_err_comb_ok", 102, int'(step_err), 0);
        @(posedge clk);
        #1;
        chk("count_after_err_clear", 103, int'(count_out), 2);
        chk("max_after_err_clear", 104, int'(max_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
